// File: rtl/sync_inc_counter_pkg.sv
// sync_counter_pkg: shared constants, toggle type, terminal-value helper
// for the synchronous modulo-N counter slice (SYNC_INC_COUNTER_DOWN_EN).
package sync_counter_pkg;

  localparam int MAX_WIDTH = 16;

  // One T-input per counter bit; counters declare toggle_t [WIDTH-1:0].
  typedef logic toggle_t;

  // Count value at which the counter wraps in the given direction.
  function automatic int terminal_value(int modulus, bit up);
    return up ? (modulus - 1) : 0;
  endfunction

endpackage

// File: rtl/sync_inc_counter_if.sv
// sync_inc_counter_if: control/status bundle of one counter.
// master drives enable/load/load_value (+up_down), slave returns status.
interface sync_inc_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
`ifdef SYNC_INC_COUNTER_DOWN_EN
  logic             up_down;
`endif
  logic [WIDTH-1:0] count;
  logic             terminal;
  logic             wrap;
  logic             load_clamped;

  modport master (
    output enable, load, load_value,
`ifdef SYNC_INC_COUNTER_DOWN_EN
    output up_down,
`endif
    input  count, terminal, wrap, load_clamped
  );

  modport slave (
    input  enable, load, load_value,
`ifdef SYNC_INC_COUNTER_DOWN_EN
    input  up_down,
`endif
    output count, terminal, wrap, load_clamped
  );
endinterface

// File: rtl/sync_inc_counter_t_stage.sv
// t_stage_sync: one T flip-flop, falling-edge clocked, sync clear.
// Ports: clock, clear (active high), t (toggle), q (state).
module t_stage_sync (
  input  logic clock,
  input  logic clear,
  input  logic t,
  output logic q
);
  logic q_r = 1'b0;

  always_ff @(negedge clock) begin
    if (clear) q_r <= 1'b0;
    else       q_r <= q_r ^ t;
  end

  assign q = q_r;
endmodule

// File: rtl/sync_inc_counter.sv
// sync_inc_counter: synchronous modulo-MODULUS counter of T stages.
// Ports: clock, clear, bus (slave). Option: SYNC_INC_COUNTER_DOWN_EN.
module sync_inc_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic               clock,
  input logic               clear,
  sync_inc_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] TOP =
    WIDTH'(terminal_value(MODULUS, 1'b1));
  localparam logic [WIDTH-1:0] BOT =
    WIDTH'(terminal_value(MODULUS, 1'b0));
  // Full binary range: the +1 carry chain wraps by itself.
  localparam bit POW2 = (MODULUS == (1 << WIDTH));

  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    nxt;
  toggle_t [WIDTH-1:0] tog;
  logic                up;
  logic                at_top;
  logic                at_bot;
  logic                over;
  logic                wrap_r = 1'b0;
  logic                clamp_r = 1'b0;

`ifdef SYNC_INC_COUNTER_DOWN_EN
  assign up = bus.up_down;
`else
  assign up = 1'b1;
`endif

  assign at_top = (count == TOP);
  assign at_bot = (count == BOT);
  assign over   = (bus.load_value > TOP);

  always_comb begin
    nxt = count;
    if (bus.load) begin
      nxt = over ? TOP : bus.load_value;
    end else if (bus.enable) begin
      if (up)
        nxt = (!POW2 && at_top) ? '0 : count + 1'b1;
      else
        nxt = at_bot ? TOP : count - 1'b1;
    end
  end

  // Each stage flips exactly where current and next state differ.
  assign tog = count ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_stage_sync u_t (
      .clock (clock),
      .clear (clear),
      .t     (tog[i]),
      .q     (count[i])
    );
  end

  always_ff @(negedge clock) begin
    if (clear) begin
      wrap_r  <= 1'b0;
      clamp_r <= 1'b0;
    end else if (bus.load) begin
      wrap_r  <= 1'b0;
      clamp_r <= over;
    end else if (bus.enable) begin
      wrap_r  <= up ? at_top : at_bot;
      clamp_r <= 1'b0;
    end else begin
      wrap_r  <= 1'b0;
      clamp_r <= 1'b0;
    end
  end

  assign bus.count        = count;
  assign bus.terminal     = bus.enable & (up ? at_top : at_bot);
  assign bus.wrap         = wrap_r;
  assign bus.load_clamped = clamp_r;
endmodule

// File: tb/tb_sync_inc_counter.sv
// tb_sync_inc_counter: directed scoreboard bench, M=16, M=10, cascade.
// Optional decrement checks under SYNC_INC_COUNTER_DOWN_EN.
module tb_sync_inc_counter;
  import sync_counter_pkg::*;

  localparam int W   = 4;
  localparam int M16 = 16;
  localparam int M10 = 10;

  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic clr16 = 1'b0;
  logic clr10 = 1'b0;
  logic clrc  = 1'b0;

  sync_inc_counter_if #(.WIDTH(W)) if16 ();
  sync_inc_counter_if #(.WIDTH(W)) if10 ();
  sync_inc_counter_if #(.WIDTH(W)) ifl ();
  sync_inc_counter_if #(.WIDTH(W)) ifh ();

  sync_inc_counter #(.WIDTH(W), .MODULUS(M16)) u16 (
    .clock (clock), .clear (clr16), .bus (if16.slave));
  sync_inc_counter #(.WIDTH(W), .MODULUS(M10)) u10 (
    .clock (clock), .clear (clr10), .bus (if10.slave));
  sync_inc_counter #(.WIDTH(W), .MODULUS(M16)) ulo (
    .clock (clock), .clear (clrc), .bus (ifl.slave));
  sync_inc_counter #(.WIDTH(W), .MODULUS(M16)) uhi (
    .clock (clock), .clear (clrc), .bus (ifh.slave));

  assign ifl.load       = 1'b0;
  assign ifl.load_value = '0;
  assign ifh.load       = 1'b0;
  assign ifh.load_value = '0;
  assign ifh.enable     = ifl.terminal;
`ifdef SYNC_INC_COUNTER_DOWN_EN
  assign if10.up_down = 1'b1;
  assign ifl.up_down  = 1'b1;
  assign ifh.up_down  = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         id;
    logic [31:0] cnt;
    logic [31:0] wrp;
    logic [31:0] clp;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] obs_cnt(int id);
    case (id)
      0:       return 32'(if16.count);
      1:       return 32'(if10.count);
      default: return 32'({ifh.count, ifl.count});
    endcase
  endfunction

  function automatic logic [31:0] obs_wrp(int id);
    case (id)
      0:       return 32'(if16.wrap);
      1:       return 32'(if10.wrap);
      default: return 32'(ifh.wrap);
    endcase
  endfunction

  function automatic logic [31:0] obs_clp(int id);
    case (id)
      0:       return 32'(if16.load_clamped);
      1:       return 32'(if10.load_clamped);
      default: return 32'(ifl.load_clamped | ifh.load_clamped);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int id, int c, int w, int k);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.cnt = 32'(c);
    e.wrp = 32'(w);
    e.clp = 32'(k);
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".count"}, obs_cnt(e.id), e.cnt);
      chk({e.tag, ".wrap"},  obs_wrp(e.id), e.wrp);
      chk({e.tag, ".clamp"}, obs_clp(e.id), e.clp);
    end
  endtask

  initial begin
    if (W < 1 || W > MAX_WIDTH || M10 < 2 || M10 > (1 << W)
        || M16 < 2 || M16 > (1 << W)) begin
      $display("FAIL elab illegal WIDTH/MODULUS");
      $fatal(1, "illegal parameters");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int m;
    int v;
    int wraps;
`ifdef SYNC_INC_COUNTER_DOWN_EN
    if16.up_down = 1'b1;
`endif
    if16.enable = 0; if16.load = 0; if16.load_value = '0;
    if10.enable = 0; if10.load = 0; if10.load_value = '0;
    ifl.enable = 0;
    #1;
    chk("start16", obs_cnt(0), 0);
    chk("start10", obs_cnt(1), 0);

    // clocked clear on every counter
    clr16 = 1; clr10 = 1; clrc = 1;
    push("rst16", 0, 0, 0, 0);
    push("rst10", 1, 0, 0, 0);
    push("rstc", 2, 0, 0, 0);
    tick();
    clr16 = 0; clr10 = 0; clrc = 0;

    // modulo-16 run, 20 edges
    if16.enable = 1;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("m16.term", 32'(if16.terminal), 32'(m == 15));
      push("m16.run", 0, (m + 1) % 16, int'(m == 15), 0);
      m = (m + 1) % 16;
      tick();
    end
    if16.enable = 0;
    push("m16.hold", 0, m, 0, 0);
    tick();

    // modulo-10 run, 12 edges
    if10.enable = 1;
    m = 0;
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      push("m10.run", 1, (m + 1) % 10, int'(m == 9), 0);
      m = (m + 1) % 10;
      tick();
      wraps += int'(if10.wrap);
    end
    chk("m10.wraps", 32'(wraps), 1);

    // out-of-range load clamps, then wraps
    if10.enable = 0; if10.load = 1; if10.load_value = 4'd12;
    push("m10.ld12", 1, 9, 0, 1);
    tick();
    if10.load = 0;
    #1;
    chk("m10.term_off", 32'(if10.terminal), 0);
    if10.enable = 1;
    #1;
    chk("m10.term_on", 32'(if10.terminal), 1);
    push("m10.wrap", 1, 0, 1, 0);
    tick();

    // boundary loads: 9 is legal, 10 is clamped
    if10.enable = 0; if10.load = 1; if10.load_value = 4'd9;
    push("m10.ld9", 1, 9, 0, 0);
    tick();
    if10.load_value = 4'd10;
    push("m10.ld10", 1, 9, 0, 1);
    tick();
    if10.load = 0;
    push("m10.clampoff", 1, 9, 0, 0);
    tick();

    // clear beats load and enable
    if10.load = 1; if10.load_value = 4'd5;
    push("m10.ld5", 1, 5, 0, 0);
    tick();
    clr10 = 1; if10.load_value = 4'd3; if10.enable = 1;
    push("m10.clrwin", 1, 0, 0, 0);
    tick();
    clr10 = 0; if10.load = 0; if10.enable = 0;

    // load beats enable
    if10.load = 1; if10.load_value = 4'd4; if10.enable = 1;
    push("m10.ldwin", 1, 4, 0, 0);
    tick();
    if10.enable = 0;

    // hold at 7, mid-cycle clear waits for the edge
    if10.load_value = 4'd7;
    push("m10.ld7", 1, 7, 0, 0);
    tick();
    if10.load = 0;
    for (int i = 0; i < 3; i++) begin
      push("m10.hold", 1, 7, 0, 0);
      tick();
      chk("m10.hold_term", 32'(if10.terminal), 0);
    end
    clr10 = 1;
    #3;
    chk("m10.clr_mid", obs_cnt(1), 7);
    push("m10.clr_edge", 1, 0, 0, 0);
    tick();
    clr10 = 0;

    // cascade: 256 edges through 0xFF back to 0x00
    ifl.enable = 1;
    v = 0;
    wraps = 0;
    for (int i = 0; i < 256; i++) begin
      v = (v + 1) % 256;
      push("casc", 2, v, int'(v == 0), 0);
      tick();
      wraps += int'(ifh.wrap);
    end
    chk("casc.hiwraps", 32'(wraps), 1);
    ifl.enable = 0;

`ifdef SYNC_INC_COUNTER_DOWN_EN
    clr16 = 1;
    push("dn.rst", 0, 0, 0, 0);
    tick();
    clr16 = 0;
    if16.up_down = 0; if16.enable = 1;
    #1;
    chk("dn.term", 32'(if16.terminal), 1);
    push("dn.wrap", 0, 15, 1, 0);
    tick();
    push("dn.step", 0, 14, 0, 0);
    tick();
    if16.enable = 0; if16.up_down = 1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
